comp_window_minmax: RTL and testbench
=====================================

// Module: comp_window_minmax
// PURPOSE
//  Streaming min/max tracker that sits directly downstream of the n-bit comparator.
//  It consumes comparator results (agb/alb/aeb) to reduce a window of WIN unsigned
//  N-bit samples to its minimum and maximum, along with the index of each.
//  It instantiates the comparator twice and registers one result per window.
//  A valid/ready output handshake carries the result to the stage that follows.
// PARAMETERS
//  N    5  sample width in bits, unsigned; must be >= 1
//  WIN  8  samples per window; must be >= 2
//  IW   $clog2(WIN)  index width; localparam, not overridable
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   reset: synchronous, active-low
//  clr          in   1   synchronous abort: discard the partial window or pending result
//  in_valid     in   1   in_data is valid this cycle
//  in_ready     out  1   block accepts a sample this cycle
//  in_data      in   N   unsigned sample
//  out_valid    out  1   result is valid; held until it is accepted
//  out_ready    in   1   downstream accepts the result
//  out_min      out  N   window minimum
//  out_max      out  N   window maximum
//  out_min_idx  out  IW  position of the first occurrence of the minimum (0 = first sample)
//  out_max_idx  out  IW  position of the first occurrence of the maximum
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge)
//   - All outputs go to 0; the FSM goes to IDLE; the sample count goes to 0.
//   - Reset takes priority over clr, which takes priority over all other inputs.
//  FSM states: IDLE, ACC, HOLD
//   - A sample is accepted when in_valid & in_ready at a clk edge.
//   - in_ready is 1 in IDLE and ACC, and 0 in HOLD. It is a pure function of state.
//   - IDLE: an accepted sample loads cur_min = cur_max = in_data, both indices = 0,
//     count = 1, and moves to ACC.
//   - ACC: an accepted sample is compared with both comparators:
//     - cmp_lo(a=in_data, b=cur_min): if alb, cur_min <= in_data and min_idx <= count.
//     - cmp_hi(a=in_data, b=cur_max): if agb, cur_max <= in_data and max_idx <= count.
//     - aeb updates neither value; the earliest index is kept on ties.
//     - count increments. On the sample where count == WIN-1, the final min/max
//       (including that sample) are written to the out_* registers and the FSM
//       moves to HOLD.
//   - HOLD: out_valid = 1 and the out_* registers stay stable. When out_ready = 1,
//     out_valid drops at that edge and the FSM returns to IDLE.
//  Latency
//   - out_valid rises on the edge that accepts the WIN-th sample.
//   - The next window can start one cycle after the result is accepted.
//   - Throughput is one window per WIN+1 cycles when both sides stream continuously.
//  Boundaries and simultaneous events
//   - in_valid = 0 mid-window: state is held and there is no timeout.
//   - out_ready asserted outside HOLD: ignored.
//   - clr: returns to IDLE, clears count, and forces out_valid to 0. A pending HOLD
//     result is dropped. A sample presented in the same cycle as clr is discarded.
//   - Reset mid-window or during HOLD: same effect as the reset described above.
//   - Arithmetic is unsigned and compares all N bits; 0 and 2^N-1 are legal values.
// STRUCTURE
//  - Shared package comp_pkg holds the FSM state encoding (IDLE=2'd0, ACC=2'd1,
//    HOLD=2'd2) and a clog2 helper function.
//  - Sub-module: comp_nbit #(.N(N)), instantiated as cmp_lo and cmp_hi. Only alb
//    from cmp_lo and agb from cmp_hi are used.
//  - Top level: one FSM, the count register, the running min/max and index
//    registers, and the output registers.
// TESTING  (N=5, WIN=4 unless stated)
//  - Stream 9,20,16,3 with out_ready=1:
//    -> out_min=3, min_idx=3, out_max=20, max_idx=1.
//    -> out_valid high for exactly 1 cycle, rising on the edge that accepts the 4th sample.
//  - Ties, stream 6,6,6,6:
//    -> min=max=6, both indices 0.
//    Then stream 7,2,7,2:
//    -> min=2, idx 1; max=7, idx 0.
//  - Extremes, stream 31,0,31,0:
//    -> min=0, idx 1; max=31, idx 0.
//  - Backpressure: out_ready=0 for 5 cycles after out_valid rises.
//    -> out_* stable and in_ready=0 throughout; the new window starts only after the handshake.
//  - clr after 2 of 4 samples, then stream 1,2,3,4:
//    -> min=1, idx 0; max=4, idx 3.
//    -> No result is emitted for the aborted window.
//  - rst_n=0 for 1 cycle while in HOLD:
//    -> all outputs 0 on the next edge and in_ready=1.
//    -> the following window of 5,5,9,1 gives min=1, idx 3; max=9, idx 2.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared definitions for the comparator-based window min/max tracker:
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Number of bits needed to index 'value' distinct positions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/comp_nbit.sv
// Unsigned N-bit magnitude comparator: exactly one of agb/alb/aeb is high.
module comp_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         agb,
    output logic         alb,
    output logic         aeb
);

    assign agb = (a > b);
    assign alb = (a < b);
    assign aeb = (a == b);

endmodule

// File: rtl/comp_window_minmax.sv
// Streaming min/max tracker: reduces each window of WIN samples to its minimum,
// maximum and first-occurrence indices, handed off over a valid/ready port.
//
//   state | meaning
//   IDLE  | waiting for the first sample of a window
//   ACC   | accumulating samples 2..WIN against the running min/max
//   HOLD  | result presented on out_*, waiting for out_ready
module comp_window_minmax
    import comp_pkg::*;
#(
    parameter  int N   = 5,
    parameter  int WIN = 8,
    localparam int IW  = clog2(WIN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_min,
    output logic [N-1:0]  out_max,
    output logic [IW-1:0] out_min_idx,
    output logic [IW-1:0] out_max_idx
);

    localparam logic [IW-1:0] LAST_IDX = IW'(WIN - 1);

    state_t        state;
    logic [IW-1:0] count;
    logic [N-1:0]  cur_min;
    logic [N-1:0]  cur_max;
    logic [IW-1:0] cur_min_idx;
    logic [IW-1:0] cur_max_idx;

    logic          lo_agb, lo_alb, lo_aeb;
    logic          hi_agb, hi_alb, hi_aeb;
    logic          unused_cmp;

    logic [N-1:0]  nxt_min;
    logic [N-1:0]  nxt_max;
    logic [IW-1:0] nxt_min_idx;
    logic [IW-1:0] nxt_max_idx;

    comp_nbit #(.N(N)) cmp_lo (
        .a   (in_data),
        .b   (cur_min),
        .agb (lo_agb),
        .alb (lo_alb),
        .aeb (lo_aeb)
    );

    comp_nbit #(.N(N)) cmp_hi (
        .a   (in_data),
        .b   (cur_max),
        .agb (hi_agb),
        .alb (hi_alb),
        .aeb (hi_aeb)
    );

    assign unused_cmp = ^{lo_agb, lo_aeb, hi_alb, hi_aeb};

    // Strict compares only, so on ties the earlier index is kept.
    assign nxt_min     = lo_alb ? in_data : cur_min;
    assign nxt_min_idx = lo_alb ? count   : cur_min_idx;
    assign nxt_max     = hi_agb ? in_data : cur_max;
    assign nxt_max_idx = hi_agb ? count   : cur_max_idx;

    assign in_ready = (state != HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            cur_min     <= '0;
            cur_max     <= '0;
            cur_min_idx <= '0;
            cur_max_idx <= '0;
            out_valid   <= 1'b0;
            out_min     <= '0;
            out_max     <= '0;
            out_min_idx <= '0;
            out_max_idx <= '0;
        end else if (clr) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur_min     <= in_data;
                        cur_max     <= in_data;
                        cur_min_idx <= '0;
                        cur_max_idx <= '0;
                        count       <= IW'(1);
                        state       <= ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        cur_min     <= nxt_min;
                        cur_max     <= nxt_max;
                        cur_min_idx <= nxt_min_idx;
                        cur_max_idx <= nxt_max_idx;
                        if (count == LAST_IDX) begin
                            count       <= '0;
                            out_min     <= nxt_min;
                            out_max     <= nxt_max;
                            out_min_idx <= nxt_min_idx;
                            out_max_idx <= nxt_max_idx;
                            out_valid   <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            count <= count + IW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_window_minmax.sv
// Bench for comp_window_minmax (N=5, WIN=4): directed windows plus random traffic
// checked every cycle against a queue-based window reference model.
module tb_comp_window_minmax;

    localparam int N   = 5;
    localparam int WIN = 4;
    localparam int IW  = 2;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_min;
    logic [N-1:0]  out_max;
    logic [IW-1:0] out_min_idx;
    logic [IW-1:0] out_max_idx;

    int checks;
    int failures;

    // reference model state
    logic [N-1:0] win_q[$];
    bit           m_known;
    bit           m_hold;
    bit           m_chk_data;
    int           m_min, m_max, m_min_idx, m_max_idx;

    comp_window_minmax #(.N(N), .WIN(WIN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_min     (out_min),
        .out_max     (out_max),
        .out_min_idx (out_min_idx),
        .out_max_idx (out_max_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            win_q.delete();
            m_hold = 0; m_chk_data = 1; m_known = 1;
            m_min = 0; m_max = 0; m_min_idx = 0; m_max_idx = 0;
        end else if (clr) begin
            win_q.delete();
            m_hold = 0; m_chk_data = 0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 0; m_chk_data = 0;
            end
        end else if (in_valid) begin
            win_q.push_back(in_data);
            if (win_q.size() == WIN) begin
                m_min = win_q[0]; m_min_idx = 0;
                m_max = win_q[0]; m_max_idx = 0;
                for (int i = 1; i < WIN; i++) begin
                    if (win_q[i] < m_min) begin m_min = win_q[i]; m_min_idx = i; end
                    if (win_q[i] > m_max) begin m_max = win_q[i]; m_max_idx = i; end
                end
                m_hold = 1;
                win_q.delete();
            end
        end
    endtask

    // Check outputs against the model, advance one clock, update the model.
    task automatic step();
        if (m_known) begin
            check_val("in_ready", 32'(in_ready), 32'(!m_hold));
            check_val("out_valid", 32'(out_valid), 32'(m_hold));
            if (m_hold || m_chk_data) begin
                check_val("out_min", 32'(out_min), m_min);
                check_val("out_max", 32'(out_max), m_max);
                check_val("out_min_idx", 32'(out_min_idx), m_min_idx);
                check_val("out_max_idx", 32'(out_max_idx), m_max_idx);
            end
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cyc(input logic v, input logic [N-1:0] d, input logic ordy,
                       input logic c, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr       = c;
        rst_n     = r;
        step();
    endtask

    task automatic feed(input int a, input int b, input int c, input int d, input logic ordy);
        int s[4];
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        for (int i = 0; i < 4; i++) cyc(1'b1, N'(s[i]), ordy, 1'b0, 1'b1);
    endtask

    task automatic expect_res(input int mn, input int mn_idx, input int mx, input int mx_idx);
        check_val("res_valid", 32'(out_valid), 1);
        check_val("res_min", 32'(out_min), mn);
        check_val("res_min_idx", 32'(out_min_idx), mn_idx);
        check_val("res_max", 32'(out_max), mx);
        check_val("res_max_idx", 32'(out_max_idx), mx_idx);
    endtask

    function automatic logic [N-1:0] rand_sample();
        int sel;
        sel = int'($urandom_range(0, 3));
        if (sel == 0) return ($urandom_range(0, 1) != 0) ? N'(31) : N'(0);
        if (sel == 1) return N'($urandom_range(4, 6));
        return N'($urandom_range(0, 31));
    endfunction

    initial begin
        checks = 0; failures = 0;
        m_known = 0; m_hold = 0; m_chk_data = 0;
        m_min = 0; m_max = 0; m_min_idx = 0; m_max_idx = 0;

        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_in_ready", 32'(in_ready), 1);
        check_val("rst_out_min", 32'(out_min), 0);
        check_val("rst_out_max", 32'(out_max), 0);

        // basic stream, result accepted immediately
        feed(9, 20, 16, 3, 1'b1);
        expect_res(3, 3, 20, 1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check_val("one_cycle_valid", 32'(out_valid), 0);

        feed(6, 6, 6, 6, 1'b1);
        expect_res(6, 0, 6, 0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        feed(7, 2, 7, 2, 1'b1);
        expect_res(2, 1, 7, 0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        feed(31, 0, 31, 0, 1'b1);
        expect_res(0, 1, 31, 0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // backpressure with samples offered the whole time
        feed(10, 11, 12, 13, 1'b0);
        for (int i = 0; i < 5; i++) begin
            expect_res(10, 0, 13, 3);
            check_val("bp_in_ready", 32'(in_ready), 0);
            cyc(1'b1, rand_sample(), 1'b0, 1'b0, 1'b1);
        end
        cyc(1'b1, N'(1), 1'b1, 1'b0, 1'b1);
        feed(4, 8, 2, 8, 1'b0);
        expect_res(2, 2, 8, 1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // abort a partial window; sample in the clr cycle is dropped
        feed(30, 31, 30, 31, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, N'(25), 1'b1, 1'b0, 1'b1);
        cyc(1'b1, N'(0), 1'b1, 1'b0, 1'b1);
        cyc(1'b1, N'(17), 1'b1, 1'b1, 1'b1);
        check_val("clr_valid", 32'(out_valid), 0);
        feed(1, 2, 3, 4, 1'b0);
        expect_res(1, 0, 4, 3);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // reset while holding a result
        feed(12, 3, 28, 5, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, N'(9), 1'b1, 1'b1, 1'b0);
        check_val("hold_rst_valid", 32'(out_valid), 0);
        check_val("hold_rst_in_ready", 32'(in_ready), 1);
        check_val("hold_rst_min", 32'(out_min), 0);
        check_val("hold_rst_max", 32'(out_max), 0);
        check_val("hold_rst_min_idx", 32'(out_min_idx), 0);
        check_val("hold_rst_max_idx", 32'(out_max_idx), 0);
        feed(5, 5, 9, 1, 1'b0);
        expect_res(1, 3, 9, 2);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 9) < 7),
                rand_sample(),
                ($urandom_range(0, 1) != 0),
                ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 199) != 0));
        end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
